pe_ws_bank: RTL and testbench

Next-generation weight-stationary processing element for the systolic MAC array. It holds a bank of NUM_W selectable weights, loaded synchronously by a small load FSM, and replaces the old weight-strobe-as-clock scheme. Each valid cycle it performs a signed multiply-accumulate in one of two modes: pass-through partial sum, or local accumulate. It forwards the input element east and the partial sum south, one register stage each, and carries a valid flag alongside the data.

---
 rtl/pe_pkg.sv | 42 ++++
 rtl/pe_ws_bank_mac.sv | 36 +++
 rtl/pe_ws_bank.sv | 111 +++++++++++
 tb/tb_pe_ws_bank.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the weight-stationary PE.
// Holds the load FSM states, MAC mode codes and the saturating reducer.
package pe_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_LOAD
  } state_t;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  localparam int SAT_W = 64;

  typedef struct packed {
    logic                    ovf;
    logic signed [SAT_W-1:0] val;
  } sat_t;

  // Clamp a wide signed value into an acc_w-bit signed range.
  function automatic sat_t sat_reduce(
    input logic signed [SAT_W-1:0] value,
    input int                      acc_w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t r;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.ovf = 1'b1;
    if (value > hi) begin
      r.val = hi;
    end else if (value < lo) begin
      r.val = lo;
    end else begin
      r.val = value;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_ws_bank_mac.sv
// Combinational signed multiply-add with saturate or wrap reduction.
// The sum is formed at 2*DATA_W+1 bits before reduction to ACC_W.
module pe_mac_sat
  import pe_pkg::*;
#(
  parameter int DATA_W = 13,
  parameter int ACC_W  = 13,
  parameter int SAT_EN = 1
) (
  input  logic signed [DATA_W-1:0] ele,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [ACC_W-1:0]  addend,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  localparam int FW = 2*DATA_W + 1;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [FW-1:0]       full;
  logic signed [SAT_W-1:0]    wide;
  sat_t                       r;
  logic                       unused_hi;

  assign prod = ele * w;
  assign full = FW'(prod) + FW'(addend);
  assign wide = SAT_W'(full);
  assign r    = sat_reduce(wide, ACC_W);

  assign sum = (SAT_EN != 0) ? r.val[ACC_W-1:0]
                             : full[ACC_W-1:0];
  assign ovf = r.ovf;

  assign unused_hi = ^r.val[SAT_W-1:ACC_W];

endmodule

// File: rtl/pe_ws_bank.sv
// Weight-stationary PE with a synchronously loaded weight bank.
// Forwards elements east and partial sums south, one register each.
module pe_ws_bank
  import pe_pkg::*;
#(
  parameter int DATA_W = 13,
  parameter int ACC_W  = 13,
  parameter int NUM_W  = 4,
  parameter int SAT_EN = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_ele,
  input  logic [ACC_W-1:0]         in_psum,
  input  logic [$clog2(NUM_W)-1:0] wsel,
  input  logic                     mode,
  input  logic                     acc_clr,
  input  logic                     load_start,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_ele,
  output logic [ACC_W-1:0]         out_psum,
  output logic                     busy,
  output logic                     load_done,
  output logic                     sat_flag
);

  localparam int SEL_W = $clog2(NUM_W);

  state_t            state;
  state_t            state_n;
  logic [SEL_W-1:0]  cnt;
  logic [DATA_W-1:0] bank [NUM_W];
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  sum;
  logic              ovf;
  logic              mac_en;
  logic              wr_en;
  logic              last_wr;

  assign mac_en  = (state == ST_IDLE) && in_valid;
  assign wr_en   = (state == ST_LOAD) && in_valid;
  assign last_wr = wr_en && (cnt == SEL_W'(NUM_W - 1));
  assign busy    = (state == ST_LOAD);

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (load_start) state_n = ST_LOAD;
      ST_LOAD: if (last_wr)    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // A cleared accumulate starts from zero in the same cycle.
  always_comb begin
    addend = in_psum;
    if (mode == MODE_ACC) addend = acc_clr ? '0 : acc;
  end

  pe_mac_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_mac (
    .ele    (in_ele),
    .w      (bank[wsel]),
    .addend (addend),
    .sum    (sum),
    .ovf    (ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      for (int i = 0; i < NUM_W; i++) bank[i] <= '0;
    end else if ((state == ST_IDLE) && load_start) begin
      cnt <= '0;
    end else if (wr_en) begin
      bank[cnt] <= in_ele;
      cnt       <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ele   <= '0;
      out_psum  <= '0;
      load_done <= 1'b0;
      sat_flag  <= 1'b0;
      acc       <= '0;
    end else begin
      out_valid <= mac_en;
      load_done <= last_wr;
      if (in_valid) out_ele <= in_ele;
      if (mac_en) begin
        out_psum <= sum;
        if (ovf) sat_flag <= 1'b1;
      end
      if (mac_en && (mode == MODE_ACC)) acc <= sum;
      else if (acc_clr)                 acc <= '0;
    end
  end

endmodule

// File: tb/tb_pe_ws_bank.sv
// Self-checking bench for pe_ws_bank: saturating and wrapping instances
// share stimulus; expected outputs flow through a scoreboard queue.
module tb_pe_ws_bank;

  localparam int DW = 13;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_ele;
  logic [AW-1:0] in_psum;
  logic [1:0]    wsel;
  logic          mode;
  logic          acc_clr;
  logic          load_start;

  logic          out_valid, busy, load_done, sat_flag;
  logic [DW-1:0] out_ele;
  logic [AW-1:0] out_psum;
  logic          w_valid, w_busy, w_done, w_sat;
  logic [DW-1:0] w_ele;
  logic [AW-1:0] w_psum;

  always #5 clk = ~clk;

  pe_ws_bank #(.DATA_W(DW), .ACC_W(AW), .NUM_W(4), .SAT_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ele(in_ele),
    .in_psum(in_psum), .wsel(wsel), .mode(mode), .acc_clr(acc_clr),
    .load_start(load_start), .out_valid(out_valid), .out_ele(out_ele),
    .out_psum(out_psum), .busy(busy), .load_done(load_done),
    .sat_flag(sat_flag)
  );

  pe_ws_bank #(.DATA_W(DW), .ACC_W(AW), .NUM_W(4), .SAT_EN(0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ele(in_ele),
    .in_psum(in_psum), .wsel(wsel), .mode(mode), .acc_clr(acc_clr),
    .load_start(load_start), .out_valid(w_valid), .out_ele(w_ele),
    .out_psum(w_psum), .busy(w_busy), .load_done(w_done),
    .sat_flag(w_sat)
  );

  typedef struct {
    logic iv;
    int   ele;
    int   psum;
    int   wsel;
    logic mode;
    logic clr;
    logic ev;
    int   eele;
    int   epsum;
    int   ewrap;
  } vec_t;

  typedef struct {
    logic ev;
    int   eele;
    int   epsum;
    int   ewrap;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[16];
  int   n_run = 0;
  int   n_fail = 0;

  function automatic int sx(input logic [12:0] x);
    return int'($signed(x));
  endfunction

  function automatic vec_t mk(input logic iv, input int ele, input int psum,
                              input int ws, input logic md, input logic clr,
                              input logic ev, input int eele, input int ep,
                              input int ew);
    vec_t v;
    v.iv = iv; v.ele = ele; v.psum = psum; v.wsel = ws;
    v.mode = md; v.clr = clr; v.ev = ev; v.eele = eele;
    v.epsum = ep; v.ewrap = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input int ele, input int psum,
                       input int ws, input logic md, input logic clr,
                       input logic ls);
    in_valid   = iv;
    in_ele     = ele[DW-1:0];
    in_psum    = psum[AW-1:0];
    wsel       = ws[1:0];
    mode       = md;
    acc_clr    = clr;
    load_start = ls;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".valid"}, int'(out_valid), int'(e.ev));
      chk({tag, ".ele"}, sx(out_ele), e.eele);
      chk({tag, ".psum"}, sx(out_psum), e.epsum);
      chk({tag, ".wvalid"}, int'(w_valid), int'(e.ev));
      chk({tag, ".wpsum"}, sx(w_psum), e.ewrap);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    e.ev = v.ev; e.eele = v.eele; e.epsum = v.epsum; e.ewrap = v.ewrap;
    drive(v.iv, v.ele, v.psum, v.wsel, v.mode, v.clr, 1'b0);
    sbq.push_back(e);
    tick();
    check_out(tag);
  endtask

  task automatic load4(input int w0, input int w1, input int w2,
                       input int w3);
    int w[4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ld.busy%0d", i), int'(busy), 1);
      drive(1'b1, w[i], 0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      chk($sformatf("ld.oval%0d", i), int'(out_valid), 0);
      chk($sformatf("ld.oele%0d", i), sx(out_ele), w[i]);
      chk($sformatf("ld.done%0d", i), int'(load_done), (i == 3) ? 1 : 0);
    end
    chk("ld.busy_end", int'(busy), 0);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ld.done_gone", int'(load_done), 0);
    chk("ld.oval_idle", int'(out_valid), 0);
  endtask

  initial begin
    // Bank {3,-2,5,7}: read back each weight, then MAC patterns.
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 1, 1, 3, 3);
    tbl[1]  = mk(1, 1, 0, 1, 0, 0, 1, 1, -2, -2);
    tbl[2]  = mk(1, 1, 0, 2, 0, 0, 1, 1, 5, 5);
    tbl[3]  = mk(1, 1, 0, 3, 0, 0, 1, 1, 7, 7);
    tbl[4]  = mk(1, 4, 10, 1, 0, 0, 1, 4, 2, 2);
    tbl[5]  = mk(1, 1, 0, 3, 1, 1, 1, 1, 7, 7);
    tbl[6]  = mk(1, 1, 0, 3, 1, 0, 1, 1, 14, 14);
    tbl[7]  = mk(1, 1, 0, 3, 1, 0, 1, 1, 21, 21);
    tbl[8]  = mk(1, 2, 0, 3, 1, 1, 1, 2, 14, 14);
    tbl[9]  = mk(1, 3, 1, 2, 0, 0, 1, 3, 16, 16);
    tbl[10] = mk(0, 9, 100, 2, 0, 0, 0, 3, 16, 16);
    tbl[11] = mk(1, -1, 0, 0, 0, 0, 1, -1, -3, -3);
    tbl[12] = mk(1, 2, -5, 1, 0, 1, 1, 2, -9, -9);
    tbl[13] = mk(1, 1, 0, 0, 1, 0, 1, 1, 3, 3);
    tbl[14] = mk(0, 1, 0, 0, 1, 1, 0, 1, 3, 3);
    tbl[15] = mk(1, 1, 0, 0, 1, 0, 1, 1, 3, 3);

    reset = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.ele", sx(out_ele), 0);
    chk("rst.psum", sx(out_psum), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(load_done), 0);
    chk("rst.sat", int'(sat_flag), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    load4(3, -2, 5, 7);
    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));
    chk("nosat.flag", int'(sat_flag), 0);
    chk("nosat.wflag", int'(w_sat), 0);

    // Largest positive and negative products overflow 13 bits.
    load4(4095, -4096, 0, 0);
    apply(mk(1, 4095, 0, 0, 0, 0, 1, 4095, 4095, 1), "satpos");
    chk("satpos.flag", int'(sat_flag), 1);
    chk("satpos.wflag", int'(w_sat), 1);
    apply(mk(1, 4095, 0, 1, 0, 0, 1, 4095, -4096, -4096), "satneg");

    // Stalled load with a redundant load_start in the middle.
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    begin
      int siv[7] = '{1, 0, 1, 0, 1, 0, 1};
      int sel[7] = '{1, 99, 2, 99, 3, 99, 4};
      int sls[7] = '{0, 1, 0, 0, 1, 0, 0};
      for (int k = 0; k < 7; k++) begin
        drive(siv[k][0], sel[k], 0, 0, 1'b0, 1'b0, sls[k][0]);
        tick();
        chk($sformatf("stall.busy%0d", k), int'(busy), (k == 6) ? 0 : 1);
        chk($sformatf("stall.done%0d", k), int'(load_done),
            (k == 6) ? 1 : 0);
        chk($sformatf("stall.oval%0d", k), int'(out_valid), 0);
      end
    end
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall.done_gone", int'(load_done), 0);
    for (int i = 0; i < 4; i++)
      apply(mk(1, 1, 0, i, 0, 0, 1, 1, i + 1, i + 1),
            $sformatf("stall.rd%0d", i));

    // Reset in the middle of a load discards the partial bank.
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 10, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 11, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mid.busy_pre", int'(busy), 1);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid.busy", int'(busy), 0);
    chk("mid.sat", int'(sat_flag), 0);
    chk("mid.psum", sx(out_psum), 0);
    chk("mid.ele", sx(out_ele), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++)
      apply(mk(1, 1, 5, i, 0, 0, 1, 1, 5, 5), $sformatf("mid.rd%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
